ring_count_reader: RTL and testbench

- Decodes a captured 3-digit decimal Johnson-code ring-oscillator count (hundreds/tens/units, 5 bits per digit) into a binary value 0..999.
- Computes the modular delta against the previous good sample, giving the ring frequency as counts per sample interval.
- Sits after the capture stage in the ring-measurement path, in the i_clk domain, and feeds the LED/scan output logic.

---
 rtl/ring_pkg.sv | 39 +++
 rtl/johnson_digit_dec.sv | 36 +++
 rtl/ring_count_reader.sv | 175 +++++++++++++++++
 tb/tb_ring_count_reader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// ring_pkg: shared definitions for the ring-oscillator count reader.
//   - widths of one Johnson digit and of the decoded binary value
//   - count modulus
//   - the ten legal Johnson digit codes (digit 0..9)
//   - FSM state type
//   - shift-add helper for acc*10 + digit
package ring_pkg;

  localparam int DIGIT_W  = 5;
  localparam int VALUE_W  = 10;
  localparam int RING_MOD = 1000;

  localparam logic [DIGIT_W-1:0] JC_0 = 5'b00000;
  localparam logic [DIGIT_W-1:0] JC_1 = 5'b00001;
  localparam logic [DIGIT_W-1:0] JC_2 = 5'b00011;
  localparam logic [DIGIT_W-1:0] JC_3 = 5'b00111;
  localparam logic [DIGIT_W-1:0] JC_4 = 5'b01111;
  localparam logic [DIGIT_W-1:0] JC_5 = 5'b11111;
  localparam logic [DIGIT_W-1:0] JC_6 = 5'b11110;
  localparam logic [DIGIT_W-1:0] JC_7 = 5'b11100;
  localparam logic [DIGIT_W-1:0] JC_8 = 5'b11000;
  localparam logic [DIGIT_W-1:0] JC_9 = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_100   = 3'd1,
    S_010   = 3'd2,
    S_001   = 3'd3,
    S_DELTA = 3'd4
  } ring_state_t;

  // acc*10 + d as (acc<<3)+(acc<<1)+d; callers keep acc <= 99 so the
  // result never exceeds 999 and fits VALUE_W.
  function automatic logic [VALUE_W-1:0] mul10_add(input logic [VALUE_W-1:0] acc,
                                                   input logic [3:0]         d);
    return (acc << 3) + (acc << 1) + {{(VALUE_W-4){1'b0}}, d};
  endfunction

endpackage

// File: rtl/johnson_digit_dec.sv
// johnson_digit_dec: combinational decode of one 5-bit Johnson digit.
// Ports:
//   code  - 5-bit Johnson code
//   digit - decoded digit 0..9 (0 for any illegal code)
//   legal - 1 when code is one of the ten legal patterns
module johnson_digit_dec
  import ring_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic [3:0]         digit,
  output logic               legal
);

  logic [2:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < DIGIT_W; i++) begin
      ones = ones + {2'b00, code[i]};
    end

    legal = code inside {JC_0, JC_1, JC_2, JC_3, JC_4,
                         JC_5, JC_6, JC_7, JC_8, JC_9};

    // Lower half of the sequence fills from the lsb, upper half drains,
    // so msb selects between popcount and 10-popcount.
    if (!legal) begin
      digit = 4'd0;
    end else if (code[DIGIT_W-1]) begin
      digit = 4'd10 - {1'b0, ones};
    end else begin
      digit = {1'b0, ones};
    end
  end

endmodule

// File: rtl/ring_count_reader.sv
// ring_count_reader: decodes a captured 3-digit Johnson-code ring count
// into binary 0..999 and the modular delta against the last good sample.
//
// Optional build macro: RING_READER_SYNC_EN -- when defined, i_start and
// the three digit inputs pass through a 2-flop synchronizer (reset to 0),
// adding two cycles of latency.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             decode request, honoured only in IDLE
//   i_100/i_010/i_001   hundreds/tens/units Johnson digits
//   o_busy              FSM not in IDLE
//   o_valid             one-cycle result strobe
//   o_value             decoded count (partial decode on a bad sample)
//   o_delta             (value - prev) mod pMOD, held on a bad sample
//   o_first             no previous good sample existed
//   o_bad               current sample had an illegal digit code
//   o_err               sticky (pSTICKY_ERR=1) or last-sample error flag
//
// state   | meaning
// S_IDLE  | waiting for start; snapshot inputs on start
// S_100   | acc = hundreds digit
// S_010   | acc = acc*10 + tens digit
// S_001   | acc = acc*10 + units digit
// S_DELTA | register results, strobe o_valid
module ring_count_reader
  import ring_pkg::*;
#(
  parameter int pMOD        = RING_MOD,
  parameter bit pSTICKY_ERR = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [DIGIT_W-1:0] i_100,
  input  logic [DIGIT_W-1:0] i_010,
  input  logic [DIGIT_W-1:0] i_001,
  output logic               o_busy,
  output logic               o_valid,
  output logic [VALUE_W-1:0] o_value,
  output logic [VALUE_W-1:0] o_delta,
  output logic               o_first,
  output logic               o_bad,
  output logic               o_err
);

  localparam logic [VALUE_W:0] MOD_W = pMOD[VALUE_W:0];

  logic               start_use;
  logic [DIGIT_W-1:0] c100_use, c010_use, c001_use;

`ifdef RING_READER_SYNC_EN
  logic [3*DIGIT_W:0] sync1, sync2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {i_start, i_100, i_010, i_001};
      sync2 <= sync1;
    end
  end

  assign {start_use, c100_use, c010_use, c001_use} = sync2;
`else
  assign {start_use, c100_use, c010_use, c001_use} = {i_start, i_100, i_010, i_001};
`endif

  ring_state_t state, state_next;

  logic [DIGIT_W-1:0] snap_100, snap_010, snap_001;
  logic [3:0]         d100, d010, d001;
  logic               l100, l010, l001;
  logic [VALUE_W-1:0] acc;
  logic [VALUE_W-1:0] prev;
  logic               prev_ok;
  logic               sample_bad;
  logic [VALUE_W:0]   delta_wide;
  logic [VALUE_W-1:0] delta_calc;

  johnson_digit_dec u_dec_100 (.code(snap_100), .digit(d100), .legal(l100));
  johnson_digit_dec u_dec_010 (.code(snap_010), .digit(d010), .legal(l010));
  johnson_digit_dec u_dec_001 (.code(snap_001), .digit(d001), .legal(l001));

  assign sample_bad = ~(l100 & l010 & l001);

  always_comb begin
    if (acc >= prev) begin
      delta_wide = {1'b0, acc} - {1'b0, prev};
    end else begin
      delta_wide = {1'b0, acc} + MOD_W - {1'b0, prev};
    end
    delta_calc = delta_wide[VALUE_W-1:0];
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_use) state_next = S_100;
      S_100:   state_next = S_010;
      S_010:   state_next = S_001;
      S_001:   state_next = S_DELTA;
      S_DELTA: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    o_busy = (state != S_IDLE);
  end

  // Datapath and registered results
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      snap_100 <= '0;
      snap_010 <= '0;
      snap_001 <= '0;
      acc      <= '0;
      prev     <= '0;
      prev_ok  <= 1'b0;
      o_valid  <= 1'b0;
      o_value  <= '0;
      o_delta  <= '0;
      o_first  <= 1'b1;
      o_bad    <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_use) begin
            snap_100 <= c100_use;
            snap_010 <= c010_use;
            snap_001 <= c001_use;
          end
        end
        S_100: acc <= {{(VALUE_W-4){1'b0}}, d100};
        S_010: acc <= mul10_add(acc, d010);
        S_001: acc <= mul10_add(acc, d001);
        S_DELTA: begin
          o_valid <= 1'b1;
          o_value <= acc;
          o_bad   <= sample_bad;
          o_first <= ~prev_ok;
          // A bad sample leaves o_delta and the reference untouched so the
          // next good sample measures from the last trustworthy count.
          if (!sample_bad) begin
            o_delta <= prev_ok ? delta_calc : '0;
            prev    <= acc;
            prev_ok <= 1'b1;
          end
          if (pSTICKY_ERR) begin
            o_err <= o_err | sample_bad;
          end else begin
            o_err <= sample_bad;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_count_reader.sv
// tb_ring_count_reader: directed stimulus with a per-cycle behavioural
// model comparison plus literal expectations on key samples.
module tb_ring_count_reader;

`ifdef RING_READER_SYNC_EN
  localparam int LAT         = 6;
  localparam int HOLD_VALIDS = 3;
  localparam int HOLD_IDLES  = 5;
`else
  localparam int LAT         = 4;
  localparam int HOLD_VALIDS = 4;
  localparam int HOLD_IDLES  = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] c100 = '0, c010 = '0, c001 = '0;
  logic       o_busy, o_valid, o_first, o_bad, o_err;
  logic [9:0] o_value, o_delta;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  ring_count_reader dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_100(c100), .i_010(c010), .i_001(c001),
    .o_busy(o_busy), .o_valid(o_valid), .o_value(o_value),
    .o_delta(o_delta), .o_first(o_first), .o_bad(o_bad), .o_err(o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] jc(input int d);
    case (d)
      0: return 5'b00000;
      1: return 5'b00001;
      2: return 5'b00011;
      3: return 5'b00111;
      4: return 5'b01111;
      5: return 5'b11111;
      6: return 5'b11110;
      7: return 5'b11100;
      8: return 5'b11000;
      9: return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic jdec(input logic [4:0] code, output int d, output bit ok);
    d = 0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (jc(i) == code) begin
        d = i;
        ok = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: occupancy countdown, snapshot, arithmetic result.
  int         m_cnt = 0;
  int         m_value = 0, m_delta = 0, m_prev = 0;
  bit         m_valid = 0, m_first = 1, m_bad = 0, m_err = 0, m_prev_ok = 0;
  logic [4:0] s100, s010, s001;
  logic       h_st[2];
  logic [4:0] h100[2], h010[2], h001[2];

  task automatic model_finish();
    int  d1, d2, d3, v;
    bit  k1, k2, k3, bad;
    jdec(s100, d1, k1);
    jdec(s010, d2, k2);
    jdec(s001, d3, k3);
    v = 100 * d1 + 10 * d2 + d3;
    bad = !(k1 && k2 && k3);
    m_valid = 1'b1;
    m_value = v;
    m_bad = bad;
    m_first = !m_prev_ok;
    if (!bad) begin
      m_delta = m_prev_ok ? (v - m_prev + 1000) % 1000 : 0;
      m_prev = v;
      m_prev_ok = 1'b1;
    end
    m_err = m_err | bad;
  endtask

  task automatic model_step();
    logic       st;
    logic [4:0] a, b, c;
    if (rst) begin
      m_cnt = 0; m_valid = 0; m_value = 0; m_delta = 0; m_first = 1;
      m_bad = 0; m_err = 0; m_prev_ok = 0; m_prev = 0;
      for (int i = 0; i < 2; i++) begin
        h_st[i] = 1'b0; h100[i] = '0; h010[i] = '0; h001[i] = '0;
      end
      return;
    end
`ifdef RING_READER_SYNC_EN
    st = h_st[1]; a = h100[1]; b = h010[1]; c = h001[1];
    h_st[1] = h_st[0]; h100[1] = h100[0]; h010[1] = h010[0]; h001[1] = h001[0];
    h_st[0] = start;   h100[0] = c100;    h010[0] = c010;    h001[0] = c001;
`else
    st = start; a = c100; b = c010; c = c001;
`endif
    m_valid = 1'b0;
    if (m_cnt == 0) begin
      if (st) begin
        s100 = a; s010 = b; s001 = c;
        m_cnt = 4;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) model_finish();
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("busy", int'(o_busy), int'(m_cnt != 0));
      check("valid", int'(o_valid), int'(m_valid));
      check("value", int'(o_value), m_value);
      check("delta", int'(o_delta), m_delta);
      check("first", int'(o_first), int'(m_first));
      check("bad", int'(o_bad), int'(m_bad));
      check("err", int'(o_err), int'(m_err));
    end
  end

  task automatic sample(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                        input int ev, input int ed, input int ef, input int eb,
                        input string tag);
    int k;
    @(negedge clk);
    c100 = a; c010 = b; c001 = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c100 = 5'($urandom); c010 = 5'($urandom); c001 = 5'($urandom);
    k = 1;
    while (!o_valid && k < 12) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, k - 1, LAT);
    check({tag, "_value"}, int'(o_value), ev);
    check({tag, "_delta"}, int'(o_delta), ed);
    check({tag, "_first"}, int'(o_first), ef);
    check({tag, "_bad"}, int'(o_bad), eb);
  endtask

  initial begin
    int nv, ni;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", int'(o_busy), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_value", int'(o_value), 0);
    check("rst_delta", int'(o_delta), 0);
    check("rst_first", int'(o_first), 1);
    check("rst_bad", int'(o_bad), 0);
    check("rst_err", int'(o_err), 0);
    rst = 1'b0;

    sample(jc(3), jc(7), jc(2), 372, 0, 1, 0, "s372");
    sample(jc(0), jc(1), jc(5), 15, 643, 0, 0, "s015");
    sample(jc(9), jc(9), jc(9), 999, 984, 0, 0, "s999");
    sample(jc(0), jc(0), jc(0), 0, 1, 0, 0, "wrap");
    sample(jc(0), jc(0), jc(0), 0, 0, 0, 0, "repeat");
    sample(jc(1), 5'b01010, jc(0), 100, 0, 0, 1, "badten");
    check("badten_err", int'(o_err), 1);
    sample(jc(1), jc(0), jc(0), 100, 100, 0, 0, "after_bad");
    check("after_bad_err", int'(o_err), 1);

    // start held high continuously
    @(negedge clk);
    c100 = jc(1); c010 = jc(2); c001 = jc(3); start = 1'b1;
    nv = 0; ni = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (o_valid) nv++;
      if (!o_busy) ni++;
    end
    start = 1'b0;
    check("hold_valids", nv, HOLD_VALIDS);
    check("hold_idle_cycles", ni, HOLD_IDLES);
    repeat (10) @(negedge clk);

    // second pulse lands while the FSM is in S010
    c100 = jc(4); c010 = jc(5); c001 = jc(6); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nv = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (o_valid) nv++;
    end
    check("ignored_pulse_valids", nv, 1);

    // reset while in S010
    c100 = jc(7); c010 = jc(8); c001 = jc(9); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LAT - 3) @(negedge clk);
    check("pre_rst_busy", int'(o_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(o_busy), 0);
    check("abort_valid", int'(o_valid), 0);
    check("abort_first", int'(o_first), 1);
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_valid) nv++;
    end
    check("abort_no_valid", nv, 0);

    sample(jc(0), jc(4), jc(2), 42, 0, 1, 0, "post_rst");
    check("post_rst_err", int'(o_err), 0);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
